sync_fifo_fwft: RTL and testbench

Parametrised synchronous FIFO for the pixel/line-buffer datapath. It replaces the fixed 24x256 FIFO. The block adds:
- power-of-two depth with derived pointer widths;
- protected full/empty;
- programmable almost-full/almost-empty flags;
- an occupancy count;
- sticky overflow/underflow flags;
- an optional first-word-fall-through (FWFT) read mode.

It sits between the camera/pixel producers and the filter/line-delay consumers.

---
 rtl/fifo_pkg.sv | 26 ++
 rtl/sync_fifo_fwft_sdp_ram.sv | 35 +++
 rtl/sync_fifo_fwft.sv | 167 ++++++++++++++++
 tb/tb_sync_fifo_fwft.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the pixel/line-buffer FIFOs: default sizes,
// read-mode constants and a constant-foldable clog2 for pointer widths.
package fifo_pkg;

    // RGB888 pixel and one video line of storage
    localparam int PIXEL_WIDTH = 24;
    localparam int LINE_DEPTH  = 1024;

    // Read-mode selector values for the FWFT parameter
    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Number of address bits needed to index 'value' entries
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft_sdp_ram.sv
// Simple dual-port RAM: synchronous write port, registered read port
// gated by re. No reset on storage or read register so it maps onto block RAM.
module sdp_ram
    import fifo_pkg::*;
#(
    parameter int WIDTH = PIXEL_WIDTH,
    parameter int DEPTH = LINE_DEPTH,
    localparam int AW   = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port: store the word on an accepted write
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: read-first, so a same-address write returns the old word
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sync_fifo_fwft.sv
// Parametrised synchronous FIFO with occupancy count, almost-full/empty
// flags, sticky overflow/underflow, and a standard or first-word-fall-through
// read side.
//
// Handshake: a write is taken on a clock edge when wr_en=1 and the FIFO is
// not full (or a read is taken in the same cycle); a read is taken when
// rd_en=1 and empty=0. In standard mode the word appears on dout with a
// one-cycle valid pulse on the cycle after the read; in FWFT mode valid=1
// means dout already holds the head word and rd_en acknowledges it.
module sync_fifo_fwft
    import fifo_pkg::*;
#(
    parameter int WIDTH     = PIXEL_WIDTH,
    parameter int DEPTH     = LINE_DEPTH,
    parameter int FWFT      = FIFO_MODE_STD,
    parameter int AF_THRESH = DEPTH - 4,
    parameter int AE_THRESH = 4,
    localparam int AW       = clog2(DEPTH),
    localparam int CW       = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             empty,
    output logic             full,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    data_count,
    output logic             overflow,
    output logic             underflow
);

    localparam bit            IS_FWFT  = (FWFT == FIFO_MODE_FWFT);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AF   = CW'(AF_THRESH);
    localparam logic [CW-1:0] CNT_AE   = CW'(AE_THRESH);

    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;      // total words held, including FWFT stages
    logic [CW-1:0]    ram_words_q;  // words still in memory, not yet fetched
    logic             mid_valid_q;  // FWFT: RAM read register holds a fetched word
    logic             valid_q;
    logic [WIDTH-1:0] dout_q;       // FWFT output register
    logic             seen_q;       // standard mode: RAM read register is meaningful
    logic             overflow_q;
    logic             underflow_q;

    logic [WIDTH-1:0] ram_rdata;
    logic             empty_c;
    logic             full_c;
    logic             wr_acc;
    logic             rd_acc;
    logic             ram_re;
    logic             out_ready;
    logic             mid_move;

    // Accept decisions and the FWFT prefetch controls
    always_comb begin
        empty_c   = IS_FWFT ? !valid_q : (count_q == '0);
        full_c    = (count_q == CNT_FULL);
        rd_acc    = rd_en & !empty_c;
        wr_acc    = wr_en & (!full_c | rd_acc);
        out_ready = !valid_q | rd_acc;
        mid_move  = IS_FWFT & mid_valid_q & out_ready;
        if (IS_FWFT) begin
            ram_re = (ram_words_q != '0) & (!mid_valid_q | mid_move);
        end else begin
            ram_re = rd_acc;
        end
    end

    // Pointers and occupancy counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ram_words_q <= '0;
        end else if (clr) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ram_words_q <= '0;
        end else begin
            if (wr_acc) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (ram_re) rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
            case ({wr_acc, ram_re})
                2'b10:   ram_words_q <= ram_words_q + CNT_ONE;
                2'b01:   ram_words_q <= ram_words_q - CNT_ONE;
                default: ram_words_q <= ram_words_q;
            endcase
        end
    end

    // Sticky error flags: a rejected request latches until reset or clr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (clr) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_en && !wr_acc) overflow_q  <= 1'b1;
            if (rd_en && !rd_acc) underflow_q <= 1'b1;
        end
    end

    // Output stage: read pulse in standard mode, two-stage prefetch in FWFT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mid_valid_q <= 1'b0;
            valid_q     <= 1'b0;
            dout_q      <= '0;
            seen_q      <= 1'b0;
        end else if (clr) begin
            mid_valid_q <= 1'b0;
            valid_q     <= 1'b0;
            dout_q      <= '0;
            seen_q      <= 1'b0;
        end else if (IS_FWFT) begin
            mid_valid_q <= ram_re | (mid_valid_q & !mid_move);
            valid_q     <= mid_move | (valid_q & !rd_acc);
            if (mid_move) dout_q <= ram_rdata;
        end else begin
            valid_q <= rd_acc;
            if (rd_acc) seen_q <= 1'b1;
        end
    end

    sdp_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr_q),
        .wdata (din),
        .re    (ram_re),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    assign dout         = IS_FWFT ? dout_q : (seen_q ? ram_rdata : '0);
    assign valid        = valid_q;
    assign empty        = empty_c;
    assign full         = full_c;
    assign almost_full  = (count_q >= CNT_AF);
    assign almost_empty = (count_q <= CNT_AE);
    assign data_count   = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Directed bench for sync_fifo_fwft: one standard-mode and one FWFT-mode
// instance (WIDTH=24, DEPTH=8, AF_THRESH=6, AE_THRESH=2) share stimulus.
module tb_sync_fifo_fwft;

    localparam int W  = 24;
    localparam int D  = 8;
    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic          clr;
    logic [W-1:0]  din;
    logic          wr_en;
    logic          rd_en;

    logic [W-1:0]  s_dout, f_dout;
    logic          s_valid, f_valid;
    logic          s_empty, f_empty;
    logic          s_full, f_full;
    logic          s_af, f_af;
    logic          s_ae, f_ae;
    logic [CW-1:0] s_count, f_count;
    logic          s_ovf, f_ovf;
    logic          s_unf, f_unf;

    int checks;
    int errors;
    logic [W-1:0] exp_q[$];

    sync_fifo_fwft #(.WIDTH(W), .DEPTH(D), .FWFT(0), .AF_THRESH(6), .AE_THRESH(2)) u_std (
        .clk(clk), .rst_n(rst_n), .clr(clr), .din(din), .wr_en(wr_en), .rd_en(rd_en),
        .dout(s_dout), .valid(s_valid), .empty(s_empty), .full(s_full),
        .almost_full(s_af), .almost_empty(s_ae), .data_count(s_count),
        .overflow(s_ovf), .underflow(s_unf)
    );

    sync_fifo_fwft #(.WIDTH(W), .DEPTH(D), .FWFT(1), .AF_THRESH(6), .AE_THRESH(2)) u_fwft (
        .clk(clk), .rst_n(rst_n), .clr(clr), .din(din), .wr_en(wr_en), .rd_en(rd_en),
        .dout(f_dout), .valid(f_valid), .empty(f_empty), .full(f_full),
        .almost_full(f_af), .almost_empty(f_ae), .data_count(f_count),
        .overflow(f_ovf), .underflow(f_unf)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic write_words(input int n, input logic [W-1:0] base);
        for (int i = 0; i < n; i++) begin
            din   = base + W'(i);
            wr_en = 1'b1;
            exp_q.push_back(din);
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic read_words(input int n, input string tag);
        logic [W-1:0] exp;
        for (int i = 0; i < n; i++) begin
            rd_en = 1'b1;
            tick();
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            check({tag, "_valid"}, 32'(s_valid), 32'd1);
            check({tag, "_dout"}, 32'(s_dout), 32'(exp));
        end
        rd_en = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        clr    = 1'b0;
        din    = '0;
        wr_en  = 1'b0;
        rd_en  = 1'b0;

        // Reset values
        tick();
        tick();
        check("rst_count", 32'(s_count), 32'd0);
        check("rst_empty", 32'(s_empty), 32'd1);
        check("rst_full", 32'(s_full), 32'd0);
        check("rst_valid", 32'(s_valid), 32'd0);
        check("rst_af", 32'(s_af), 32'd0);
        check("rst_ae", 32'(s_ae), 32'd1);
        check("rst_dout", 32'(s_dout), 32'd0);
        check("rst_ovf", 32'(s_ovf), 32'd0);
        check("rst_unf", 32'(s_unf), 32'd0);
        check("rst_f_empty", 32'(f_empty), 32'd1);
        check("rst_f_valid", 32'(f_valid), 32'd0);
        check("rst_f_dout", 32'(f_dout), 32'd0);
        rst_n = 1'b1;
        tick();

        // Fill 1..8 and watch the flags
        for (int i = 1; i <= 8; i++) begin
            din   = W'(i);
            wr_en = 1'b1;
            exp_q.push_back(din);
            tick();
            check("fill_count", 32'(s_count), 32'(i));
            check("fill_full", 32'(s_full), 32'(i == 8));
            check("fill_af", 32'(s_af), 32'(i >= 6));
            check("fill_ae", 32'(s_ae), 32'(i <= 2));
        end
        wr_en = 1'b0;

        // Drain in order, valid one cycle after each read
        read_words(8, "drain");
        check("drain_count", 32'(s_count), 32'd0);
        check("drain_empty", 32'(s_empty), 32'd1);
        check("drain_ae", 32'(s_ae), 32'd1);
        tick();
        check("drain_valid_pulse", 32'(s_valid), 32'd0);
        check("drain_dout_hold", 32'(s_dout), 32'h000008);

        // Overflow on a full FIFO, then underflow on an empty one
        write_words(8, 24'h000010);
        din   = 24'hABCDEF;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        check("ovf_flag", 32'(s_ovf), 32'd1);
        check("ovf_count", 32'(s_count), 32'd8);
        read_words(8, "ovf_drain");
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("unf_flag", 32'(s_unf), 32'd1);
        check("unf_valid", 32'(s_valid), 32'd0);
        do_clr();
        check("clr_ovf", 32'(s_ovf), 32'd0);
        check("clr_unf", 32'(s_unf), 32'd0);
        check("clr_count", 32'(s_count), 32'd0);
        check("clr_dout", 32'(s_dout), 32'd0);

        // Simultaneous read and write at full
        write_words(8, 24'h000020);
        din   = 24'h000055;
        wr_en = 1'b1;
        rd_en = 1'b1;
        exp_q.push_back(din);
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("rw_full_count", 32'(s_count), 32'd8);
        check("rw_full_ovf", 32'(s_ovf), 32'd0);
        check("rw_full_valid", 32'(s_valid), 32'd1);
        check("rw_full_dout", 32'(s_dout), 32'h000020);
        void'(exp_q.pop_front());
        read_words(8, "rw_full_drain");

        // Simultaneous read and write at empty: no bypass
        din   = 24'h000066;
        wr_en = 1'b1;
        rd_en = 1'b1;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("rw_empty_count", 32'(s_count), 32'd1);
        check("rw_empty_unf", 32'(s_unf), 32'd1);
        check("rw_empty_valid", 32'(s_valid), 32'd0);
        exp_q.push_back(24'h000066);
        read_words(1, "rw_empty_read");
        do_clr();

        // Pointer wrap-around
        write_words(5, 24'h000030);
        read_words(5, "wrap_pre");
        write_words(8, 24'h100000);
        check("wrap_full", 32'(s_full), 32'd1);
        read_words(8, "wrap");
        check("wrap_empty", 32'(s_empty), 32'd1);

        // FWFT: fall-through latency of a single word
        do_clr();
        din   = 24'h123456;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        check("fwft_early_valid", 32'(f_valid), 32'd0);
        check("fwft_early_count", 32'(f_count), 32'd1);
        tick();
        tick();
        check("fwft_valid", 32'(f_valid), 32'd1);
        check("fwft_dout", 32'(f_dout), 32'h123456);
        check("fwft_not_empty", 32'(f_empty), 32'd0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("fwft_ack_valid", 32'(f_valid), 32'd0);
        check("fwft_ack_empty", 32'(f_empty), 32'd1);
        check("fwft_ack_count", 32'(f_count), 32'd0);

        // FWFT: four words streamed with rd_en held high
        for (int i = 1; i <= 4; i++) begin
            din   = 24'h200000 + W'(i);
            wr_en = 1'b1;
            tick();
        end
        wr_en = 1'b0;
        check("fwft4_head_valid", 32'(f_valid), 32'd1);
        check("fwft4_head", 32'(f_dout), 32'h200001);
        check("fwft4_count", 32'(f_count), 32'd4);
        rd_en = 1'b1;
        for (int i = 2; i <= 4; i++) begin
            tick();
            check("fwft4_stream_valid", 32'(f_valid), 32'd1);
            check("fwft4_stream_dout", 32'(f_dout), 32'h200000 + 32'(i));
            check("fwft4_stream_count", 32'(f_count), 32'(5 - i));
        end
        tick();
        rd_en = 1'b0;
        check("fwft4_end_valid", 32'(f_valid), 32'd0);
        check("fwft4_end_empty", 32'(f_empty), 32'd1);
        check("fwft4_end_count", 32'(f_count), 32'd0);
        check("fwft4_end_unf", 32'(f_unf), 32'd0);

        // Asynchronous reset between edges with three words stored
        do_clr();
        write_words(3, 24'h300001);
        exp_q.delete();
        tick();
        tick();
        check("arst_pre_count", 32'(s_count), 32'd3);
        check("arst_pre_f_valid", 32'(f_valid), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_count", 32'(s_count), 32'd0);
        check("arst_empty", 32'(s_empty), 32'd1);
        check("arst_valid", 32'(s_valid), 32'd0);
        check("arst_dout", 32'(s_dout), 32'd0);
        check("arst_f_count", 32'(f_count), 32'd0);
        check("arst_f_valid", 32'(f_valid), 32'd0);
        check("arst_f_empty", 32'(f_empty), 32'd1);
        check("arst_f_dout", 32'(f_dout), 32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        din   = 24'h0ABCDE;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("post_rst_valid", 32'(s_valid), 32'd1);
        check("post_rst_dout", 32'(s_dout), 32'h0ABCDE);
        tick();
        check("post_rst_f_valid", 32'(f_valid), 32'd1);
        check("post_rst_f_dout", 32'(f_dout), 32'h0ABCDE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
